age_issue_queue: RTL

//  Parametrised out-of-order issue queue: successor to the fixed 4-entry ALU IQ.
//  - Accepts up to DISPATCH_CNT micro-ops per cycle and tracks REG_COUNT source operands per entry.
//  - Captures operands from CDB_COUNT broadcast channels.
//  - Issues the exact-oldest ready entry, using an age matrix rather than saturating aging counters.
//  - Sits between dispatch and one execution pipe; the issue slot is a registered valid/ready stage.

---
 rtl/age_issue_queue.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/age_issue_queue.sv
// Out-of-order issue queue that issues the oldest ready micro-op using an age matrix.
// Operands are captured from CDB broadcasts at enqueue (bypass) or while waiting.
module age_issue_queue #(
  parameter int IQ_SIZE      = 8,
  parameter int DISPATCH_CNT = 2,
  parameter int REG_COUNT    = 2,
  parameter int CDB_COUNT    = 2,
  parameter int TAG_W        = 6,
  parameter int DATA_W       = 32,
  parameter int PAYLOAD_W    = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  input  logic [DISPATCH_CNT-1:0]               enq_valid_i,
  input  logic [DISPATCH_CNT*PAYLOAD_W-1:0]     enq_payload_i,
  input  logic [DISPATCH_CNT*REG_COUNT*TAG_W-1:0]  enq_src_tag_i,
  input  logic [DISPATCH_CNT*REG_COUNT-1:0]     enq_src_rdy_i,
  input  logic [DISPATCH_CNT*REG_COUNT*DATA_W-1:0] enq_src_data_i,
  output logic                                  enq_ready_o,
  input  logic [CDB_COUNT-1:0]                  cdb_valid_i,
  input  logic [CDB_COUNT*TAG_W-1:0]            cdb_tag_i,
  input  logic [CDB_COUNT*DATA_W-1:0]           cdb_data_i,
  output logic                                  iss_valid_o,
  input  logic                                  iss_ready_i,
  output logic [PAYLOAD_W-1:0]                  iss_payload_o,
  output logic [REG_COUNT*DATA_W-1:0]           iss_src_data_o,
  output logic [$clog2(IQ_SIZE+1)-1:0]          occupancy_o
);

  localparam int OCC_W  = $clog2(IQ_SIZE+1);
  localparam int LANE_W = (DISPATCH_CNT > 1) ? $clog2(DISPATCH_CNT) : 1;
  localparam logic [OCC_W:0] FREE_NEED = (OCC_W+1)'(DISPATCH_CNT);
  localparam logic [OCC_W:0] SIZE_L    = (OCC_W+1)'(IQ_SIZE);

  logic [IQ_SIZE-1:0]       valid_r;
  logic [PAYLOAD_W-1:0]     payload_r [IQ_SIZE];
  logic [TAG_W-1:0]         tag_r     [IQ_SIZE][REG_COUNT];
  logic [REG_COUNT-1:0]     rdy_r     [IQ_SIZE];
  logic [DATA_W-1:0]        data_r    [IQ_SIZE][REG_COUNT];
  logic [IQ_SIZE-1:0]       older_r   [IQ_SIZE];
  logic                     iss_valid_r;
  logic [PAYLOAD_W-1:0]     iss_payload_r;
  logic [REG_COUNT*DATA_W-1:0] iss_data_r;
  logic [OCC_W-1:0]         occ_r;

  logic                     enq_ready_s;
  logic [IQ_SIZE-1:0]       ent_we_s;
  logic [LANE_W-1:0]        ent_lane_s  [IQ_SIZE];
  logic [OCC_W-1:0]         enq_cnt_s;
  logic [PAYLOAD_W-1:0]     lane_payload_s [DISPATCH_CNT];
  logic [TAG_W-1:0]         lane_tag_s  [DISPATCH_CNT][REG_COUNT];
  logic [REG_COUNT-1:0]     cap_rdy_s   [DISPATCH_CNT];
  logic [DATA_W-1:0]        cap_data_s  [DISPATCH_CNT][REG_COUNT];
  logic [REG_COUNT-1:0]     wk_rdy_s    [IQ_SIZE];
  logic [DATA_W-1:0]        wk_data_s   [IQ_SIZE][REG_COUNT];
  logic [IQ_SIZE-1:0]       elig_s;
  logic [IQ_SIZE-1:0]       win_s;
  logic                     load_s;
  logic [PAYLOAD_W-1:0]     win_payload_s;
  logic [REG_COUNT*DATA_W-1:0] win_data_s;
  logic [IQ_SIZE-1:0]       older_n_s   [IQ_SIZE];
  logic [OCC_W-1:0]         occ_n_s;

  // Admission check and lane-to-entry allocation (k-th valid lane takes k-th lowest free slot)
  always_comb begin
    logic [IQ_SIZE-1:0] free_v;
    logic               found;
    enq_ready_s = (({1'b0, occ_r} + FREE_NEED) <= SIZE_L);
    free_v      = ~valid_r;
    ent_we_s    = '0;
    enq_cnt_s   = '0;
    found       = 1'b0;
    for (int e = 0; e < IQ_SIZE; e++) begin
      ent_lane_s[e] = '0;
    end
    for (int k = 0; k < DISPATCH_CNT; k++) begin
      found = 1'b0;
      if (enq_valid_i[k] && enq_ready_s) begin
        for (int e = 0; e < IQ_SIZE; e++) begin
          if (!found && free_v[e]) begin
            found         = 1'b1;
            free_v[e]     = 1'b0;
            ent_we_s[e]   = 1'b1;
            ent_lane_s[e] = LANE_W'(k);
            enq_cnt_s     = enq_cnt_s + OCC_W'(1);
          end else begin
            found = found;
          end
        end
      end else begin
        found = 1'b0;
      end
    end
  end

  // Operand capture: enqueue bypass and wakeup of waiting entries; lowest CDB channel wins
  always_comb begin
    for (int k = 0; k < DISPATCH_CNT; k++) begin
      lane_payload_s[k] = enq_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
      for (int r = 0; r < REG_COUNT; r++) begin
        lane_tag_s[k][r] = enq_src_tag_i[(k*REG_COUNT+r)*TAG_W +: TAG_W];
        cap_rdy_s[k][r]  = enq_src_rdy_i[k*REG_COUNT+r];
        cap_data_s[k][r] = enq_src_data_i[(k*REG_COUNT+r)*DATA_W +: DATA_W];
        if (!enq_src_rdy_i[k*REG_COUNT+r]) begin
          for (int c = CDB_COUNT-1; c >= 0; c--) begin
            if (cdb_valid_i[c] && (cdb_tag_i[c*TAG_W +: TAG_W] == lane_tag_s[k][r])) begin
              cap_rdy_s[k][r]  = 1'b1;
              cap_data_s[k][r] = cdb_data_i[c*DATA_W +: DATA_W];
            end else begin
              cap_rdy_s[k][r]  = cap_rdy_s[k][r];
            end
          end
        end else begin
          cap_rdy_s[k][r] = 1'b1;
        end
      end
    end
    for (int i = 0; i < IQ_SIZE; i++) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        wk_rdy_s[i][r]  = rdy_r[i][r];
        wk_data_s[i][r] = data_r[i][r];
        if (!rdy_r[i][r]) begin
          for (int c = CDB_COUNT-1; c >= 0; c--) begin
            if (cdb_valid_i[c] && (cdb_tag_i[c*TAG_W +: TAG_W] == tag_r[i][r])) begin
              wk_rdy_s[i][r]  = 1'b1;
              wk_data_s[i][r] = cdb_data_i[c*DATA_W +: DATA_W];
            end else begin
              wk_rdy_s[i][r]  = wk_rdy_s[i][r];
            end
          end
        end else begin
          wk_rdy_s[i][r] = 1'b1;
        end
      end
    end
  end

  // Oldest-ready select over the age matrix and issue-register load decision
  always_comb begin
    win_payload_s = '0;
    win_data_s    = '0;
    for (int i = 0; i < IQ_SIZE; i++) begin
      elig_s[i] = valid_r[i] & (&rdy_r[i]);
    end
    for (int i = 0; i < IQ_SIZE; i++) begin
      win_s[i] = elig_s[i];
      for (int j = 0; j < IQ_SIZE; j++) begin
        if (elig_s[j] && older_r[j][i]) begin
          win_s[i] = 1'b0;
        end else begin
          win_s[i] = win_s[i];
        end
      end
    end
    for (int i = 0; i < IQ_SIZE; i++) begin
      if (win_s[i]) begin
        win_payload_s = win_payload_s | payload_r[i];
        for (int r = 0; r < REG_COUNT; r++) begin
          win_data_s[r*DATA_W +: DATA_W] = win_data_s[r*DATA_W +: DATA_W] | data_r[i][r];
        end
      end else begin
        win_payload_s = win_payload_s;
      end
    end
    load_s = (|win_s) & (~iss_valid_r | iss_ready_i);
  end

  // Next age matrix: a new entry is younger than survivors and than lower-lane peers
  always_comb begin
    for (int i = 0; i < IQ_SIZE; i++) begin
      for (int j = 0; j < IQ_SIZE; j++) begin
        if (ent_we_s[j]) begin
          older_n_s[i][j] = (valid_r[i] & ~(load_s & win_s[i]) & ~ent_we_s[i]) |
                            (ent_we_s[i] & (ent_lane_s[i] < ent_lane_s[j]));
        end else if (ent_we_s[i]) begin
          older_n_s[i][j] = 1'b0;
        end else begin
          older_n_s[i][j] = older_r[i][j];
        end
      end
    end
    occ_n_s = occ_r + enq_cnt_s - OCC_W'(load_s);
  end

  // Entry storage, age matrix, occupancy and issue register
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_r       <= '0;
      iss_valid_r   <= 1'b0;
      iss_payload_r <= '0;
      iss_data_r    <= '0;
      occ_r         <= '0;
      for (int i = 0; i < IQ_SIZE; i++) begin
        older_r[i]   <= '0;
        rdy_r[i]     <= '0;
        payload_r[i] <= '0;
        for (int r = 0; r < REG_COUNT; r++) begin
          tag_r[i][r]  <= '0;
          data_r[i][r] <= '0;
        end
      end
    end else begin
      occ_r <= occ_n_s;
      for (int i = 0; i < IQ_SIZE; i++) begin
        older_r[i] <= older_n_s[i];
        if (ent_we_s[i]) begin
          valid_r[i]   <= 1'b1;
          payload_r[i] <= lane_payload_s[ent_lane_s[i]];
          rdy_r[i]     <= cap_rdy_s[ent_lane_s[i]];
          for (int r = 0; r < REG_COUNT; r++) begin
            tag_r[i][r]  <= lane_tag_s[ent_lane_s[i]][r];
            data_r[i][r] <= cap_data_s[ent_lane_s[i]][r];
          end
        end else if (load_s && win_s[i]) begin
          valid_r[i] <= 1'b0;
        end else begin
          rdy_r[i] <= wk_rdy_s[i];
          for (int r = 0; r < REG_COUNT; r++) begin
            data_r[i][r] <= wk_data_s[i][r];
          end
        end
      end
      if (load_s) begin
        iss_valid_r   <= 1'b1;
        iss_payload_r <= win_payload_s;
        iss_data_r    <= win_data_s;
      end else if (iss_ready_i) begin
        iss_valid_r   <= 1'b0;
      end else begin
        iss_valid_r   <= iss_valid_r;
      end
    end
  end

  assign enq_ready_o    = enq_ready_s;
  assign iss_valid_o    = iss_valid_r;
  assign iss_payload_o  = iss_payload_r;
  assign iss_src_data_o = iss_data_r;
  assign occupancy_o    = occ_r;

endmodule
